// File: rtl/seg7_reader_if.sv
// Bundles the seven-segment bus being monitored and the recovered digit outputs.
// No storage: wiring only, so it adds no latency.
// No backpressure: the bus is observed passively and results are one-cycle pulses.
interface seg7_reader_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [7:0]              seg_in;
  logic [NUM_DIGITS-1:0]   dig_sel;
  logic                    clr;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   digit_valid;
  logic                    upd;
  logic                    err;
  logic [IDX_W-1:0]        idx;

  // The display side drives the bus and reads back the recovered digits.
  modport master (
    output seg_in, dig_sel, clr,
    input  value, digit_valid, upd, err, idx
  );

  // The reader watches the bus and reports what it decoded.
  modport slave (
    input  seg_in, dig_sel, clr,
    output value, digit_valid, upd, err, idx
  );
endinterface

// File: rtl/seg7_reader.sv
// Recovers hex nibbles from a multiplexed one-hot seven-segment bus once each pattern is stable.
// Latency: a pattern first sampled at edge E1 is reported on the edge E(STABLE_CYCLES+1).
// No backpressure: inputs are sampled every edge; upd/err are single-cycle pulses.
module seg7_reader #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  seg7_reader_if.slave  bus
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  logic [6:0]              seg_q, seg_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic                    upd_q, upd_d;
  logic                    err_q, err_d;
  logic [IDX_W-1:0]        idx_q, idx_d;

  logic                    sample_chg;
  logic                    new_onehot;
  logic                    capture;
  logic [4:0]              dec;

  // Inverse of the display glyph table; bit 4 flags a legal glyph, dp is never seen here.
  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] r;
    r = 5'h00;
    case (s)
      7'h7E: r = {1'b1, 4'h0};
      7'h30: r = {1'b1, 4'h1};
      7'h6D: r = {1'b1, 4'h2};
      7'h79: r = {1'b1, 4'h3};
      7'h33: r = {1'b1, 4'h4};
      7'h5B: r = {1'b1, 4'h5};
      7'h5F: r = {1'b1, 4'h6};
      7'h70: r = {1'b1, 4'h7};
      7'h7F: r = {1'b1, 4'h8};
      7'h7B: r = {1'b1, 4'h9};
      7'h77: r = {1'b1, 4'hA};
      7'h1F: r = {1'b1, 4'hB};
      7'h4E: r = {1'b1, 4'hC};
      7'h3D: r = {1'b1, 4'hD};
      7'h4F: r = {1'b1, 4'hE};
      7'h47: r = {1'b1, 4'hF};
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  // Binary index of a one-hot select (only meaningful when exactly one bit is set).
  function automatic logic [IDX_W-1:0] sel_to_idx(input logic [NUM_DIGITS-1:0] s);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (s[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  // Sample tracking: compare the incoming sample against the held one and advance the FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_d      = bus.dig_sel;
    seg_d      = bus.seg_in[6:0];
    sample_chg = (bus.dig_sel != sel_q) || (bus.seg_in[6:0] != seg_q);
    new_onehot = $onehot(bus.dig_sel);
    // The held sample has now been seen STABLE_CYCLES times in a row; report it on this edge
    // even if the incoming sample differs, since the stability requirement is already met.
    capture    = (state_q == TRACK) && (cnt_q == CNT_MAX);

    if (!new_onehot) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if ((state_q == IDLE) || sample_chg) begin
      state_d = TRACK;
      cnt_d   = CNT_ONE;
    end else begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
      if (capture) state_d = HOLD;
    end
  end

  // Capture path: decode the held pattern and update the digit store and pulses.
  always_comb begin
    value_d = value_q;
    valid_d = bus.clr ? '0 : valid_q;
    upd_d   = 1'b0;
    err_d   = 1'b0;
    idx_d   = idx_q;
    dec     = decode(seg_q);

    if (capture) begin
      idx_d = sel_to_idx(sel_q);
      if (dec[4]) begin
        upd_d = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (sel_q[i]) begin
            value_d[4*i +: 4] = dec[3:0];
            valid_d[i]        = 1'b1;
          end
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      seg_q   <= '0;
      cnt_q   <= '0;
      value_q <= '0;
      valid_q <= '0;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      valid_q <= valid_d;
      upd_q   <= upd_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.value       = value_q;
  assign bus.digit_valid = valid_q;
  assign bus.upd         = upd_q;
  assign bus.err         = err_q;
  assign bus.idx         = idx_q;
endmodule

// File: tb/tb_seg7_reader.sv
// Self-checking bench for seg7_reader: directed scenarios plus randomized bus traffic.
// Outputs are compared every cycle against a run-length model of the displayed patterns.
// No backpressure involved; stimulus is applied 1 time unit after each rising edge.
module tb_seg7_reader;
  localparam int N = 4;
  localparam int S = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg7_reader_if #(.NUM_DIGITS(N)) bus ();

  seg7_reader #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int n_upd  = 0;
  int n_err  = 0;

  logic [6:0] glyph [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the held sample and how many consecutive edges it has been seen (saturates at S+1).
  logic [6:0]     m_seg;
  logic [N-1:0]   m_sel;
  int             m_run;
  logic [4*N-1:0] e_value;
  logic [N-1:0]   e_valid;
  logic           e_upd, e_err;
  int             e_idx;
  bit             started = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_seg = '0; m_sel = '0; m_run = 0;
      e_value = '0; e_valid = '0; e_upd = 0; e_err = 0; e_idx = 0;
      started = 1;
    end else begin
      int d;
      int nib;
      e_upd = 0;
      e_err = 0;
      if (bus.clr) e_valid = '0;
      if (m_run == S && $countones(m_sel) == 1) begin
        d = 0;
        for (int i = 0; i < N; i++) if (m_sel[i]) d = i;
        nib = -1;
        for (int n = 0; n < 16; n++) if (glyph[n] == m_seg) nib = n;
        e_idx = d;
        if (nib >= 0) begin
          e_value[4*d +: 4] = 4'(nib);
          e_valid[d] = 1'b1;
          e_upd = 1;
        end else begin
          e_err = 1;
        end
      end
      if (bus.dig_sel == m_sel && bus.seg_in[6:0] == m_seg) begin
        if (m_run <= S) m_run++;
      end else begin
        m_sel = bus.dig_sel;
        m_seg = bus.seg_in[6:0];
        m_run = 1;
      end
    end
  end

  // Compare process: every cycle after the first reset edge.
  always @(negedge clk) begin
    if (started) begin
      check("value", 32'(bus.value), 32'(e_value));
      check("digit_valid", 32'(bus.digit_valid), 32'(e_valid));
      check("upd", 32'(bus.upd), 32'(e_upd));
      check("err", 32'(bus.err), 32'(e_err));
      check("idx", 32'(bus.idx), 32'(e_idx));
      if (bus.upd === 1'b1) n_upd++;
      if (bus.err === 1'b1) n_err++;
    end
  end

  task automatic drive(input logic [N-1:0] s, input logic [7:0] g, input logic c, input int n);
    repeat (n) begin
      bus.dig_sel = s;
      bus.seg_in  = g;
      bus.clr     = c;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int u0;
    int e0;
    rst = 1'b1;
    bus.seg_in  = 8'($urandom);
    bus.dig_sel = 4'($urandom);
    bus.clr     = 1'($urandom);
    repeat (2) begin
      @(posedge clk);
      #1;
      bus.seg_in  = 8'($urandom);
      bus.dig_sel = 4'($urandom);
      bus.clr     = 1'($urandom);
    end
    check("rst_value", 32'(bus.value), 0);
    check("rst_valid", 32'(bus.digit_valid), 0);
    check("rst_upd_err", {bus.upd, bus.err}, 0);
    check("rst_idx", 32'(bus.idx), 0);
    rst = 1'b0;

    // Single glyph '2' on digit 0: pulse only after the fifth edge.
    u0 = n_upd;
    drive(4'b0001, 8'h6D, 1'b0, 4);
    check("t2_no_early_upd", 32'(bus.upd), 0);
    drive(4'b0001, 8'h6D, 1'b0, 1);
    check("t2_upd", 32'(bus.upd), 1);
    check("t2_idx", 32'(bus.idx), 0);
    check("t2_value", 32'(bus.value[3:0]), 2);
    check("t2_valid", 32'(bus.digit_valid), 32'b0001);
    check("t2_model_value", 32'(e_value[3:0]), 2);
    drive(4'b0001, 8'h6D, 1'b0, 3);
    check("t2_single_pulse", n_upd - u0, 1);

    // Digit 1: a short-lived '3' is skipped, then '4' is captured.
    u0 = n_upd;
    drive(4'b0010, 8'h79, 1'b0, 3);
    drive(4'b0010, 8'h33, 1'b0, 4);
    check("t3_no_upd", n_upd - u0, 0);
    drive(4'b0010, 8'h33, 1'b0, 1);
    check("t3_upd", 32'(bus.upd), 1);
    check("t3_idx", 32'(bus.idx), 1);
    check("t3_value", 32'(bus.value[7:4]), 4);

    // Digit 2 blank: error pulse, store untouched.
    drive(4'b0100, 8'h00, 1'b0, 4);
    check("t4_no_early_err", 32'(bus.err), 0);
    drive(4'b0100, 8'h00, 1'b0, 1);
    check("t4_err", 32'(bus.err), 1);
    check("t4_no_upd", 32'(bus.upd), 0);
    check("t4_idx", 32'(bus.idx), 2);
    check("t4_value", 32'(bus.value[11:8]), 0);
    check("t4_valid", 32'(bus.digit_valid), 32'b0011);
    drive(4'b0100, 8'h00, 1'b0, 1);
    u0 = n_upd;
    e0 = n_err;
    drive(4'b0000, 8'h30, 1'b0, 10);
    drive(4'b0011, 8'h30, 1'b0, 10);
    check("t4_idle_upd", n_upd - u0, 0);
    check("t4_idle_err", n_err - e0, 0);
    drive(4'b0100, 8'h5F, 1'b0, 5);
    check("t4_digit2", 32'(bus.value[11:8]), 6);
    check("t4_valid3", 32'(bus.digit_valid), 32'b0111);

    // Digit 3: dp toggling is ignored; clr on the capture edge keeps only digit 3.
    for (int k = 0; k < 4; k++) drive(4'b1000, (k % 2 == 1) ? 8'hFE : 8'h7E, 1'b0, 1);
    drive(4'b1000, 8'h7E, 1'b1, 1);
    check("t6_upd", 32'(bus.upd), 1);
    check("t6_idx", 32'(bus.idx), 3);
    check("t6_valid", 32'(bus.digit_valid), 32'b1000);
    check("t6_value", 32'(bus.value[15:12]), 0);
    for (int k = 0; k < 6; k++) drive(4'b1000, (k % 2 == 1) ? 8'hCF : 8'h4F, 1'b0, 1);
    check("t5_dp_value", 32'(bus.value[15:12]), 32'hE);

    // Reset part-way through a count restarts the stability requirement.
    drive(4'b0001, 8'h7B, 1'b0, 3);
    rst = 1'b1;
    drive(4'b0001, 8'h7B, 1'b0, 1);
    rst = 1'b0;
    check("t6_rst_value", 32'(bus.value), 0);
    u0 = n_upd;
    drive(4'b0001, 8'h7B, 1'b0, 4);
    check("t6_rst_no_upd", n_upd - u0, 0);
    drive(4'b0001, 8'h7B, 1'b0, 1);
    check("t6_rst_upd", 32'(bus.upd), 1);
    check("t6_rst_nib", 32'(bus.value[3:0]), 9);

    // Randomized runs of select/segment patterns, with occasional clr and reset.
    for (int r = 0; r < 400; r++) begin
      logic [3:0] s;
      logic [7:0] g;
      int len;
      case ($urandom_range(0, 9))
        0:       s = 4'b0000;
        1:       s = 4'($urandom);
        default: s = 4'(1 << $urandom_range(0, 3));
      endcase
      if ($urandom_range(0, 5) == 0) g = 8'($urandom);
      else g = {1'($urandom), glyph[$urandom_range(0, 15)]};
      len = $urandom_range(1, 8);
      for (int k = 0; k < len; k++) begin
        bus.clr = ($urandom_range(0, 19) == 0);
        rst     = ($urandom_range(0, 199) == 0);
        if ($urandom_range(0, 3) == 0) g[7] = ~g[7];
        bus.dig_sel = s;
        bus.seg_in  = g;
        @(posedge clk);
        #1;
      end
    end
    rst = 1'b0;
    drive(4'b0000, 8'h00, 1'b0, 3);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
